// File: rtl/ex_mem_seq.sv
// Execute-stage sequencer for multi-cycle memory instructions (LDM/STM and SWP/SWPB).
// Stalls ID/EX via o_busy and drives one memory transfer at a time with ack handshake.
module ex_mem_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_is_ldm,
    input  logic        i_is_swp,
    input  logic        i_load,
    input  logic [31:0] i_base,
    input  logic [15:0] i_reglist,
    input  logic [3:0]  i_swp_rd,
    input  logic [3:0]  i_swp_rm,
    input  logic        i_swp_byte,
    output logic        o_busy,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [1:0]  o_mem_size,
    input  logic        i_mem_ack,
    output logic [3:0]  o_reg_code,
    output logic        o_wb_vld,
    output logic [3:0]  o_wb_code,
    output logic        o_done
);

    typedef enum logic [2:0] {
        StIdle,
        StLdm,
        StSwpRd,
        StSwpWr,
        StDone
    } state_e;

    state_e      state_q;
    logic [15:0] rem_q;
    logic [31:0] addr_q;
    logic [3:0]  rd_q;
    logic [3:0]  rm_q;
    logic        byte_q;

    logic [15:0] rem_next;
    logic [3:0]  low_idx;
    logic [1:0]  swp_size;

    // Clearing the lowest set bit walks the list in ascending register order.
    assign rem_next = rem_q & (rem_q - 16'd1);
    assign swp_size = byte_q ? 2'b00 : 2'b10;

    always_comb begin
        low_idx = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (rem_q[k]) begin
                low_idx = 4'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rem_q   <= 16'd0;
            addr_q  <= 32'd0;
            rd_q    <= 4'd0;
            rm_q    <= 4'd0;
            byte_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_start && i_is_ldm) begin
                        rem_q   <= i_reglist;
                        addr_q  <= {i_base[31:2], 2'b00};
                        state_q <= (i_reglist != 16'd0) ? StLdm : StDone;
                    end else if (i_start && i_is_swp) begin
                        addr_q  <= i_base;
                        rd_q    <= i_swp_rd;
                        rm_q    <= i_swp_rm;
                        byte_q  <= i_swp_byte;
                        state_q <= StSwpRd;
                    end
                end
                StLdm: begin
                    if (i_mem_ack) begin
                        rem_q  <= rem_next;
                        addr_q <= addr_q + 32'd4;
                        if (rem_next == 16'd0) begin
                            state_q <= StDone;
                        end
                    end
                end
                StSwpRd: begin
                    if (i_mem_ack) begin
                        state_q <= StSwpWr;
                    end
                end
                StSwpWr: begin
                    if (i_mem_ack) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        o_busy     = 1'b0;
        o_mem_req  = 1'b0;
        o_mem_we   = 1'b0;
        o_mem_addr = 32'd0;
        o_mem_size = 2'b00;
        o_reg_code = 4'd0;
        o_wb_vld   = 1'b0;
        o_wb_code  = 4'd0;
        o_done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                o_busy = i_start & (i_is_ldm | i_is_swp);
            end
            StLdm: begin
                o_busy     = 1'b1;
                o_mem_req  = 1'b1;
                o_mem_we   = ~i_load;
                o_mem_addr = addr_q;
                o_mem_size = 2'b10;
                o_reg_code = low_idx;
                o_wb_vld   = i_mem_ack & i_load;
                o_wb_code  = (i_mem_ack & i_load) ? low_idx : 4'd0;
            end
            StSwpRd: begin
                o_busy     = 1'b1;
                o_mem_req  = 1'b1;
                o_mem_addr = addr_q;
                o_mem_size = swp_size;
                o_reg_code = rd_q;
            end
            StSwpWr: begin
                // Rd is written only now so a Rd==Rm swap stores the old value.
                o_busy     = 1'b1;
                o_mem_req  = 1'b1;
                o_mem_we   = 1'b1;
                o_mem_addr = addr_q;
                o_mem_size = swp_size;
                o_reg_code = rm_q;
                o_wb_vld   = i_mem_ack;
                o_wb_code  = i_mem_ack ? rd_q : 4'd0;
            end
            StDone: begin
                o_done = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ex_mem_seq.sv
// Directed testbench for ex_mem_seq: cycle-by-cycle checks against hand-computed values.
module tb_ex_mem_seq;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_is_ldm;
    logic        i_is_swp;
    logic        i_load;
    logic [31:0] i_base;
    logic [15:0] i_reglist;
    logic [3:0]  i_swp_rd;
    logic [3:0]  i_swp_rm;
    logic        i_swp_byte;
    logic        o_busy;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [1:0]  o_mem_size;
    logic        i_mem_ack;
    logic [3:0]  o_reg_code;
    logic        o_wb_vld;
    logic [3:0]  o_wb_code;
    logic        o_done;

    int n_cmp;
    int n_err;

    ex_mem_seq dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_is_ldm   (i_is_ldm),
        .i_is_swp   (i_is_swp),
        .i_load     (i_load),
        .i_base     (i_base),
        .i_reglist  (i_reglist),
        .i_swp_rd   (i_swp_rd),
        .i_swp_rm   (i_swp_rm),
        .i_swp_byte (i_swp_byte),
        .o_busy     (o_busy),
        .o_mem_req  (o_mem_req),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_size (o_mem_size),
        .i_mem_ack  (i_mem_ack),
        .o_reg_code (o_reg_code),
        .o_wb_vld   (o_wb_vld),
        .o_wb_code  (o_wb_code),
        .o_done     (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Checks every output at the negedge of the current cycle.
    task automatic exp_out(input string tag, input logic req, input logic we,
                           input logic [31:0] addr, input logic [1:0] size,
                           input logic [3:0] code, input logic wb, input logic [3:0] wbc,
                           input logic busy, input logic done);
        @(negedge clk);
        chk({tag, ".req"},  32'(o_mem_req),  32'(req));
        chk({tag, ".we"},   32'(o_mem_we),   32'(we));
        chk({tag, ".addr"}, o_mem_addr,      addr);
        chk({tag, ".size"}, 32'(o_mem_size), 32'(size));
        chk({tag, ".code"}, 32'(o_reg_code), 32'(code));
        chk({tag, ".wb"},   32'(o_wb_vld),   32'(wb));
        chk({tag, ".wbc"},  32'(o_wb_code),  32'(wbc));
        chk({tag, ".busy"}, 32'(o_busy),     32'(busy));
        chk({tag, ".done"}, 32'(o_done),     32'(done));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_start    = 1'b0;
        i_is_ldm   = 1'b0;
        i_is_swp   = 1'b0;
        i_load     = 1'b0;
        i_base     = 32'd0;
        i_reglist  = 16'd0;
        i_swp_rd   = 4'd0;
        i_swp_rm   = 4'd0;
        i_swp_byte = 1'b0;
        i_mem_ack  = 1'b0;
    endtask

    task automatic start_ldm(input logic load, input logic [31:0] base, input logic [15:0] list,
                             input logic ack);
        i_start   = 1'b1;
        i_is_ldm  = 1'b1;
        i_is_swp  = 1'b0;
        i_load    = load;
        i_base    = base;
        i_reglist = list;
        i_mem_ack = ack;
    endtask

    task automatic start_swp(input logic [31:0] base, input logic [3:0] rd, input logic [3:0] rm,
                             input logic byt, input logic ack);
        i_start    = 1'b1;
        i_is_ldm   = 1'b0;
        i_is_swp   = 1'b1;
        i_base     = base;
        i_swp_rd   = rd;
        i_swp_rm   = rm;
        i_swp_byte = byt;
        i_mem_ack  = ack;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        exp_out("reset", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 0, 0);

        // LDM load, three registers, zero-wait ack.
        next_cycle();
        start_ldm(1'b1, 32'h0000_1000, 16'h8005, 1'b1);
        exp_out("ldm.c0", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 1, 0);
        next_cycle();
        exp_out("ldm.c1", 1, 0, 32'h0000_1000, 2'b10, 4'd0, 1, 4'd0, 1, 0);
        next_cycle();
        exp_out("ldm.c2", 1, 0, 32'h0000_1004, 2'b10, 4'd2, 1, 4'd2, 1, 0);
        next_cycle();
        exp_out("ldm.c3", 1, 0, 32'h0000_1008, 2'b10, 4'd15, 1, 4'd15, 1, 0);
        next_cycle();
        exp_out("ldm.c4", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 0, 1);
        next_cycle();
        idle_inputs();
        exp_out("ldm.c5", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 0, 0);

        // LDM store, unaligned base, three wait cycles.
        next_cycle();
        start_ldm(1'b0, 32'h0000_1003, 16'h0002, 1'b0);
        exp_out("stm.c0", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            exp_out($sformatf("stm.w%0d", i), 1, 1, 32'h0000_1000, 2'b10, 4'd1, 0, 4'd0, 1, 0);
        end
        next_cycle();
        i_mem_ack = 1'b1;
        exp_out("stm.c4", 1, 1, 32'h0000_1000, 2'b10, 4'd1, 0, 4'd0, 1, 0);
        next_cycle();
        exp_out("stm.c5", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 0, 1);
        next_cycle();
        idle_inputs();

        // LDM with empty list.
        start_ldm(1'b1, 32'h0000_5000, 16'h0000, 1'b1);
        exp_out("ldm0.c0", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 1, 0);
        next_cycle();
        exp_out("ldm0.c1", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 0, 1);
        next_cycle();
        idle_inputs();
        exp_out("ldm0.c2", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 0, 0);

        // SWPB with Rd == Rm.
        next_cycle();
        start_swp(32'h0000_2001, 4'd3, 4'd3, 1'b1, 1'b1);
        exp_out("swpb.c0", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 1, 0);
        next_cycle();
        exp_out("swpb.rd", 1, 0, 32'h0000_2001, 2'b00, 4'd3, 0, 4'd0, 1, 0);
        next_cycle();
        exp_out("swpb.wr", 1, 1, 32'h0000_2001, 2'b00, 4'd3, 1, 4'd3, 1, 0);
        next_cycle();
        exp_out("swpb.dn", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 0, 1);
        next_cycle();
        idle_inputs();

        // Word SWP with distinct Rd/Rm and one wait state on the read.
        start_swp(32'h0000_3002, 4'd5, 4'd9, 1'b0, 1'b0);
        next_cycle();
        exp_out("swp.rdw", 1, 0, 32'h0000_3002, 2'b10, 4'd5, 0, 4'd0, 1, 0);
        next_cycle();
        i_mem_ack = 1'b1;
        exp_out("swp.rd", 1, 0, 32'h0000_3002, 2'b10, 4'd5, 0, 4'd0, 1, 0);
        next_cycle();
        exp_out("swp.wr", 1, 1, 32'h0000_3002, 2'b10, 4'd9, 1, 4'd5, 1, 0);
        next_cycle();
        exp_out("swp.dn", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 0, 1);
        next_cycle();
        idle_inputs();

        // Address wraps past the top of memory.
        start_ldm(1'b1, 32'hFFFF_FFFC, 16'h0003, 1'b1);
        next_cycle();
        exp_out("wrap.c1", 1, 0, 32'hFFFF_FFFC, 2'b10, 4'd0, 1, 4'd0, 1, 0);
        next_cycle();
        exp_out("wrap.c2", 1, 0, 32'h0000_0000, 2'b10, 4'd1, 1, 4'd1, 1, 0);
        next_cycle();
        exp_out("wrap.c3", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 0, 1);
        next_cycle();
        idle_inputs();

        // Reset during the second access, with ack present in the same cycle.
        start_ldm(1'b1, 32'h0000_3000, 16'h0007, 1'b1);
        next_cycle();
        exp_out("rst.c1", 1, 0, 32'h0000_3000, 2'b10, 4'd0, 1, 4'd0, 1, 0);
        next_cycle();
        rst = 1'b1;
        exp_out("rst.c2", 1, 0, 32'h0000_3004, 2'b10, 4'd1, 1, 4'd1, 1, 0);
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        exp_out("rst.c3", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 0, 0);
        next_cycle();
        exp_out("rst.c4", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 0, 0);
        next_cycle();
        start_ldm(1'b1, 32'h0000_0040, 16'h0010, 1'b1);
        exp_out("post.c0", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 1, 0);
        next_cycle();
        exp_out("post.c1", 1, 0, 32'h0000_0040, 2'b10, 4'd4, 1, 4'd4, 1, 0);
        next_cycle();
        exp_out("post.c2", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 0, 1);
        next_cycle();
        idle_inputs();
        exp_out("post.c3", 0, 0, 32'h0, 2'b00, 4'd0, 0, 4'd0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_mem_seq.md
EX_MEM_SEQ -- requirements
Module: ex_mem_seq

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port i_start, input, 1: the instruction held at the ID/EX outputs is valid and its condition passed.
REQ-004 SHALL have ports i_is_ldm and i_is_swp, input, 1 each: instruction class, taken from the ID/EX outputs.
REQ-005 SHALL have port i_load, input, 1: LDM direction; 1 = load, 0 = store.
REQ-006 SHALL have port i_base, input, 32: LDM lowest address, or SWP address.
REQ-007 SHALL have port i_reglist, input, 16: LDM register list; bit k selects rk.
REQ-008 SHALL have ports i_swp_rd and i_swp_rm, input, 4 each; and port i_swp_byte, input, 1: SWPB when set.
REQ-009 SHALL have port o_busy, output, 1: stall request to the ID/EX register; ID/EX en = !o_busy.
REQ-010 SHALL have ports o_mem_req, output, 1; o_mem_we, output, 1; o_mem_addr, output, 32; o_mem_size, output, 2; and i_mem_ack, input, 1.
REQ-011 SHALL have port o_reg_code, output, 4: register-file index of the current transfer; it is the store-data source for stores.
REQ-012 SHALL have ports o_wb_vld, output, 1; and o_wb_code, output, 4: one-cycle load-data writeback strobe.
REQ-013 SHALL have port o_done, output, 1: one-cycle completion pulse.

Function
REQ-014 SHALL implement states IDLE, LDM, SWP_RD, SWP_WR and DONE, with a state register, a 16-bit remaining-list register and a 32-bit address register.
REQ-015 SHALL, in IDLE with i_start=1: go to LDM if i_is_ldm=1 and i_reglist!=0; go to DONE if i_is_ldm=1 and i_reglist==0; go to SWP_RD if i_is_swp=1 and i_is_ldm=0; otherwise stay in IDLE.
REQ-016 SHALL, on entry to LDM, latch i_reglist, and latch i_base with bits [1:0] forced to 0.
REQ-017 SHALL, on entry to SWP_RD, latch i_base unmodified, plus i_swp_rd, i_swp_rm and i_swp_byte.
REQ-018 SHALL drive o_busy combinationally: 1 in LDM, SWP_RD and SWP_WR, and 1 in IDLE when i_start & (i_is_ldm | i_is_swp); 0 otherwise, including in DONE.
REQ-019 SHALL, in LDM: o_mem_req=1, o_mem_we=!i_load, o_mem_size=2'b10, o_mem_addr=address register, o_reg_code=index of the lowest set bit of the remaining list.
REQ-020 SHALL, on i_mem_ack in LDM: clear that bit; add 4 to the address register modulo 2^32 (0xFFFFFFFC wraps to 0x00000000); if i_load=1, assert o_wb_vld with o_wb_code=o_reg_code in the same cycle.
REQ-021 SHALL go from LDM to DONE on the ack that empties the remaining list.
REQ-022 SHALL, in SWP_RD: o_mem_req=1, o_mem_we=0, o_mem_size=2'b00 if byte else 2'b10, o_reg_code=Rd; on ack go to SWP_WR.
REQ-023 SHALL, in SWP_WR: o_mem_req=1, o_mem_we=1, same address and size, o_reg_code=Rm; on ack assert o_wb_vld with o_wb_code=Rd and go to DONE.
REQ-024 SHALL defer the Rd writeback of a SWP to the SWP_WR ack, so that when Rd==Rm the store uses the old Rm value.
REQ-025 SHALL hold o_mem_req, o_mem_addr, o_mem_we, o_mem_size and o_reg_code stable while waiting for ack (wait states of any length allowed).
REQ-026 SHALL ignore i_mem_ack when o_mem_req=0.
REQ-027 SHALL, in DONE, assert o_done=1 for exactly one cycle, ignore i_start (the stalled instruction is still presented), and go to IDLE.
REQ-028 SHALL fix timing with zero-wait ack: an n-register LDM started at edge 0 issues requests in cycles 1..n, has o_done in cycle n+1, and holds o_busy for cycles 0..n.
REQ-029 SHALL hold o_mem_req, o_mem_we, o_wb_vld and o_done at 0 in IDLE and in DONE.
REQ-030 SHALL drive o_reg_code, o_wb_code, o_mem_addr and o_mem_size to 0 when not otherwise specified.

Reset
REQ-031 SHALL, with rst=1 at a clock edge, enter IDLE and clear the remaining-list and address registers, so that every output reads 0 in the next cycle.
REQ-032 SHALL, on reset mid-operation, abandon the transfer: no further request, no o_wb_vld, no o_done.
REQ-033 SHALL give rst priority over i_start and i_mem_ack in the same cycle.

Verification
REQ-034 SHALL cover: LDM load, base 0x1000, reglist 0x8005, ack always 1 -> requests to 0x1000/0x1004/0x1008 with codes 0/2/15, three o_wb_vld, o_done in cycle 4, o_busy cycles 0-3.
REQ-035 SHALL cover: LDM store, base 0x1003, reglist 0x0002, ack after 3 wait cycles -> address 0x1000, o_mem_we=1, code 1 held 4 cycles, no o_wb_vld.
REQ-036 SHALL cover: LDM with reglist 0 -> no o_mem_req, o_done in cycle 1, o_busy only in cycle 0.
REQ-037 SHALL cover: SWPB with Rd=Rm=3, address 0x2001 -> read, then write at 0x2001 with size 00, store code 3, single o_wb_vld code 3 on the write ack.
REQ-038 SHALL cover: LDM at base 0xFFFFFFFC with reglist 0x0003 -> second address 0x00000000.
REQ-039 SHALL cover: rst asserted during the second LDM access -> all outputs 0 next cycle, no o_done, and an i_start afterwards is accepted normally.
